// File: rtl/id_pkg.sv
// Shared types and constants for the identifier token buffer.
package id_pkg;

    localparam int unsigned DEFAULT_MAX_LEN = 16;
    localparam int unsigned CHAR_W          = 8;
    localparam int unsigned CNT_W           = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_DROP    = 2'd3
    } state_e;

    // Address width for a storage of the given depth (at least one bit).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/id_char_buf.sv
// Character storage: DEPTH x CHAR_W, one synchronous write port, one async read port.
// Contents are not reset; only indices below the current length are ever read.
module id_char_buf
    import id_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_MAX_LEN,
    parameter int unsigned AW    = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [CHAR_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [CHAR_W-1:0] rdata_o
);

    logic [CHAR_W-1:0] mem_q [DEPTH];

    // Write one character per accepted store.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/id_token_buf.sv
// Identifier token buffer: collects characters flagged by id_fsm into a local
// buffer and replays each completed identifier as a valid/ready beat stream.
// Optional feature: define ID_TOKEN_BUF_CNT_EN to enable the tok_cnt counter;
// without it tok_cnt is tied to zero.
module id_token_buf
    import id_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   char,
    input  logic                         char_vld,
    output logic                         char_rdy,
    input  logic                         id_ok,
    output logic                         tok_vld,
    input  logic                         tok_rdy,
    output logic [7:0]                   tok_data,
    output logic                         tok_last,
    output logic [$clog2(MAX_LEN+1)-1:0] tok_len,
    output logic                         ovf,
    output logic [15:0]                  tok_cnt
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned AW    = addr_w(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   tok_len_q, tok_len_d;
    logic               tok_vld_q, tok_vld_d;
    logic               tok_last_q, tok_last_d;
    logic [CHAR_W-1:0]  tok_data_q, tok_data_d;
    logic               ovf_q, ovf_d;
    logic               char_rdy_q, char_rdy_d;

    logic               xfer;
    logic               beat_done;
    logic               buf_we;
    logic [AW-1:0]      buf_waddr;
    logic [AW-1:0]      buf_raddr;
    logic [CHAR_W-1:0]  buf_rdata;

    assign xfer      = char_vld && char_rdy_q;
    assign beat_done = tok_vld_q && tok_rdy;

    id_char_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_char_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (char),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    // Next-state logic: collect, overflow into drop, delimiter into emit, beat advance.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        tok_len_d = tok_len_q;
        ovf_d     = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = AW'(len_q);
        case (state_q)
            ST_IDLE: begin
                if (xfer && id_ok) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    len_d     = LEN_ONE;
                    state_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (xfer) begin
                    if (id_ok) begin
                        if (len_q == LEN_MAX) begin
                            ovf_d   = 1'b1;
                            len_d   = '0;
                            state_d = ST_DROP;
                        end else begin
                            buf_we = 1'b1;
                            len_d  = len_q + LEN_ONE;
                        end
                    end else begin
                        idx_d     = '0;
                        tok_len_d = len_q;
                        state_d   = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (beat_done) begin
                    if (tok_last_q) begin
                        len_d   = '0;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + LEN_ONE;
                    end
                end
            end
            ST_DROP: begin
                if (xfer && !id_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign buf_raddr = AW'(idx_d);

    // Next values of the registered outputs, looked up from the upcoming beat index.
    always_comb begin
        tok_vld_d  = (state_d == ST_EMIT);
        char_rdy_d = !tok_vld_d;
        tok_data_d = tok_vld_d ? buf_rdata : '0;
        tok_last_d = tok_vld_d && (idx_d == (len_d - LEN_ONE));
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            tok_len_q  <= '0;
            tok_vld_q  <= 1'b0;
            tok_last_q <= 1'b0;
            tok_data_q <= '0;
            ovf_q      <= 1'b0;
            char_rdy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            tok_len_q  <= tok_len_d;
            tok_vld_q  <= tok_vld_d;
            tok_last_q <= tok_last_d;
            tok_data_q <= tok_data_d;
            ovf_q      <= ovf_d;
            char_rdy_q <= char_rdy_d;
        end
    end

    assign char_rdy = char_rdy_q;
    assign tok_vld  = tok_vld_q;
    assign tok_data = tok_data_q;
    assign tok_last = tok_last_q;
    assign tok_len  = tok_len_q;
    assign ovf      = ovf_q;

`ifdef ID_TOKEN_BUF_CNT_EN
    logic [CNT_W-1:0] tok_cnt_q;

    // Count tokens on their final beat handshake; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_cnt_q <= '0;
        end else if (beat_done && tok_last_q) begin
            tok_cnt_q <= tok_cnt_q + CNT_W'(1);
        end
    end

    assign tok_cnt = tok_cnt_q;
`else
    assign tok_cnt = '0;
`endif

endmodule

// File: tb/tb_id_token_buf.sv
// Self-checking bench for id_token_buf: directed scenarios plus random streams,
// compared every cycle against a queue-based model of the token stream.
module tb_id_token_buf;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       ch;
    logic             char_vld;
    logic             char_rdy;
    logic             id_ok;
    logic             tok_vld;
    logic             tok_rdy;
    logic [7:0]       tok_data;
    logic             tok_last;
    logic [LEN_W-1:0] tok_len;
    logic             ovf;
    logic [15:0]      tok_cnt;

    int checks = 0;
    int errors = 0;

    // Model: word being gathered, token being replayed, drop mode, counters.
    logic [7:0]  m_word[$];
    logic [7:0]  m_emit[$];
    bit          m_drop;
    bit          m_ovf;
    int unsigned m_tlen;
    int unsigned m_cnt;

    id_token_buf #(.MAX_LEN(MAX_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .char     (ch),
        .char_vld (char_vld),
        .char_rdy (char_rdy),
        .id_ok    (id_ok),
        .tok_vld  (tok_vld),
        .tok_rdy  (tok_rdy),
        .tok_data (tok_data),
        .tok_last (tok_last),
        .tok_len  (tok_len),
        .ovf      (ovf),
        .tok_cnt  (tok_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_word.delete();
        m_emit.delete();
        m_drop = 1'b0;
        m_ovf  = 1'b0;
        m_tlen = 0;
        m_cnt  = 0;
    endtask

    // Apply one clock edge of the token rules to the model using current inputs.
    task automatic model_edge();
        m_ovf = 1'b0;
        if (m_emit.size() != 0) begin
            if (tok_rdy) begin
                void'(m_emit.pop_front());
                if (m_emit.size() == 0) m_cnt = (m_cnt + 1) % 65536;
            end
        end else if (char_vld) begin
            if (m_drop) begin
                if (!id_ok) m_drop = 1'b0;
            end else if (id_ok) begin
                if (m_word.size() == MAX_LEN) begin
                    m_ovf  = 1'b1;
                    m_drop = 1'b1;
                    m_word.delete();
                end else begin
                    m_word.push_back(ch);
                end
            end else if (m_word.size() != 0) begin
                m_emit = m_word;
                m_tlen = m_word.size();
                m_word.delete();
            end
        end
    endtask

    function automatic int unsigned exp_cnt();
`ifdef ID_TOKEN_BUF_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs(input string ctx);
        chk({ctx, ":char_rdy"}, 32'(char_rdy), 32'(m_emit.size() == 0));
        chk({ctx, ":tok_vld"},  32'(tok_vld),  32'(m_emit.size() != 0));
        if (m_emit.size() != 0) begin
            chk({ctx, ":tok_data"}, 32'(tok_data), 32'(m_emit[0]));
            chk({ctx, ":tok_last"}, 32'(tok_last), 32'(m_emit.size() == 1));
            chk({ctx, ":tok_len"},  32'(tok_len),  m_tlen);
        end
        chk({ctx, ":ovf"},     32'(ovf),     32'(m_ovf));
        chk({ctx, ":tok_cnt"}, 32'(tok_cnt), exp_cnt());
    endtask

    task automatic step(input logic [7:0] c, input logic v, input logic ok,
                        input logic rdy, input string ctx);
        ch       = c;
        char_vld = v;
        id_ok    = ok;
        tok_rdy  = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(ctx);
    endtask

    // Feed a string; bit i of oks is id_ok for character i.
    task automatic feed(input string s, input logic [31:0] oks, input string ctx);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1'b1, oks[i], 1'b1, ctx);
        end
    endtask

    task automatic idle_cycles(input int n, input logic rdy, input string ctx);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0, rdy, ctx);
    endtask

    initial begin
        logic [7:0] c;
        rst = 1'b1; ch = 8'h00; char_vld = 1'b0; id_ok = 1'b0; tok_rdy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset:tok_data", 32'(tok_data), 32'h0);
        chk("reset:tok_len",  32'(tok_len),  32'h0);
        rst = 1'b0;

        // Three-character identifier then space.
        feed("ab1 ", 32'b0111, "ab1");
        chk("ab1:first_beat", 32'(tok_data), 32'h61);
        idle_cycles(4, 1'b1, "ab1_drain");

        // Backpressure holds the beat and blocks input.
        feed("x;", 32'b01, "x");
        for (int i = 0; i < 3; i++) step("z", 1'b1, 1'b1, 1'b0, "x_hold");
        chk("x_hold:data", 32'(tok_data), 32'h78);
        idle_cycles(3, 1'b1, "x_drain");

        // Overflow: seventeen identifier characters then space.
        for (int i = 0; i < 17; i++) step(8'h61 + 8'(i), 1'b1, 1'b1, 1'b1, "ovf");
        chk("ovf:pulse", 32'(ovf), 32'h1);
        step(" ", 1'b1, 1'b0, 1'b1, "ovf_delim");
        idle_cycles(3, 1'b1, "ovf_after");

        // Non-identifier characters produce nothing.
        feed("9a ", 32'b000, "noid");
        idle_cycles(2, 1'b1, "noid_after");

        // Reset in the middle of emission.
        feed("abc ", 32'b0111, "abc");
        step(8'h00, 1'b0, 1'b0, 1'b1, "abc_beat2");
        chk("abc_beat2:data", 32'(tok_data), 32'h62);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_async");
        chk("rst_async:tok_data", 32'(tok_data), 32'h0);
        chk("rst_async:tok_len",  32'(tok_len),  32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(2, 1'b1, "rst_after");
        feed("q ", 32'b01, "q");
        idle_cycles(3, 1'b1, "q_drain");

        // Random streams, moderate identifier density.
        for (int i = 0; i < 600; i++) begin
            c = 8'(8'h61 + 8'($urandom_range(0, 25)));
            step(c, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 3) != 0, "rand");
        end
        // Random streams biased toward long identifiers to reach overflow.
        for (int i = 0; i < 600; i++) begin
            c = 8'(8'h30 + 8'($urandom_range(0, 9)));
            step(c, $urandom_range(0, 4) != 0, $urandom_range(0, 29) != 0,
                 $urandom_range(0, 1) != 0, "rand_long");
        end
        step(" ", 1'b1, 1'b0, 1'b1, "final_delim");
        idle_cycles(MAX_LEN + 4, 1'b1, "final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_token_buf.md
ID_TOKEN_BUF -- requirements
Module: id_token_buf

Interface
REQ-001 SHALL have parameter MAX_LEN, 16, maximum stored identifier length in characters (2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port char  input  8  character byte, the same byte presented to id_fsm.
REQ-005 SHALL have port char_vld  input  1  char valid this cycle.
REQ-006 SHALL have port char_rdy  output  1  block accepts char this cycle; a transfer is char_vld && char_rdy.
REQ-007 SHALL have port id_ok  input  1  id_fsm out; high when the transferred char extends a valid identifier.
REQ-008 SHALL have port tok_vld  output  1  output beat valid.
REQ-009 SHALL have port tok_rdy  input  1  downstream accepts beat.
REQ-010 SHALL have port tok_data  output  8  identifier character of current beat.
REQ-011 SHALL have port tok_last  output  1  current beat is the final character.
REQ-012 SHALL have port tok_len  output  clog2(MAX_LEN+1)  length of the token being emitted; stable for all beats.
REQ-013 SHALL have port ovf  output  1  one-cycle pulse when an identifier exceeds MAX_LEN.
REQ-014 SHALL have port tok_cnt  output  16  count of tokens fully emitted.

Function
REQ-015 SHALL implement states IDLE, COLLECT, EMIT, DROP.
REQ-016 char_rdy SHALL be 1 in IDLE, COLLECT, DROP and 0 in EMIT.
REQ-017 IDLE: transfer with id_ok=1 SHALL store char at index 0, set len=1, go COLLECT; transfer with id_ok=0 is discarded.
REQ-018 COLLECT: transfer with id_ok=1 and len<MAX_LEN SHALL store char at index len, len+1.
REQ-019 COLLECT: transfer with id_ok=1 and len==MAX_LEN SHALL pulse ovf for one cycle, discard the buffer, go DROP.
REQ-020 COLLECT: transfer with id_ok=0 (delimiter) SHALL discard the delimiter, go EMIT with beat index 0 the next cycle.
REQ-021 EMIT: tok_vld=1, tok_data=buf[idx], tok_last=(idx==len-1); idx SHALL advance only on tok_vld && tok_rdy.
REQ-022 EMIT: tok_data/tok_last SHALL hold stable while tok_vld && !tok_rdy.
REQ-023 The last-beat handshake SHALL return to IDLE and increment tok_cnt (wraps 0xFFFF->0) in the same edge.
REQ-024 DROP: transfers with id_ok=1 SHALL be discarded; the first transfer with id_ok=0 SHALL go IDLE with no token emitted.
REQ-025 Cycles without a transfer SHALL leave state, len and buffer unchanged.
REQ-026 Latency: first tok_vld SHALL assert the cycle after the delimiter transfer; one beat per cycle when tok_rdy=1.

Reset
REQ-027 rst high SHALL asynchronously force state=IDLE, len=0, idx=0, tok_vld=0, tok_last=0, tok_data=0, tok_len=0, ovf=0, tok_cnt=0.
REQ-028 rst mid-COLLECT or mid-EMIT SHALL abandon the token; no partial token is emitted after release.
REQ-029 Buffer contents need no reset.

Configuration
REQ-030 Macro ID_TOKEN_BUF_CNT_EN defined: tok_cnt SHALL count per REQ-023.
REQ-031 Macro ID_TOKEN_BUF_CNT_EN undefined: tok_cnt SHALL be constant 0 and no counter register SHALL be inferred.

Structure
REQ-032 Shared package id_pkg SHALL hold the state encodings and the default MAX_LEN constant.
REQ-033 Character storage SHALL be a sub-module id_char_buf (MAX_LEN x 8, one write port, one async read port).

Verification
REQ-034 Stream "ab1 " with id_ok 1,1,1,0 -> after space, beats 'a','b','1'; tok_len=3, tok_last on '1', tok_cnt=1.
REQ-035 "x;" with tok_rdy low 3 cycles -> tok_vld=1, tok_data='x' held 3 cycles, char_rdy=0 throughout; beat taken on tok_rdy=1.
REQ-036 17 identifier chars then space, MAX_LEN=16 -> ovf pulse on 17th char, no tok_vld, tok_cnt unchanged.
REQ-037 "9a " (id_ok 0,0,0) -> no token, state stays IDLE.
REQ-038 rst pulse during EMIT beat 2 of "abc " -> outputs zeroed immediately; next "q " emits single beat 'q', tok_cnt=1.
REQ-039 Build without ID_TOKEN_BUF_CNT_EN, run REQ-034 stimulus -> identical beats, tok_cnt=0.
